// File: rtl/vga_out_pkg.sv
// Shared constants, pixel type and TinyVGA packing for the VGA output stage.
// Default timing is 640x480@60 (800x525 total, negative syncs).
package vga_out_pkg;

    localparam int H_ACTIVE_D = 640;
    localparam int H_FP_D     = 16;
    localparam int H_SYNC_D   = 96;
    localparam int H_BP_D     = 48;
    localparam int V_ACTIVE_D = 480;
    localparam int V_FP_D     = 10;
    localparam int V_SYNC_D   = 2;
    localparam int V_BP_D     = 33;

    localparam int H_TOTAL = H_ACTIVE_D + H_FP_D + H_SYNC_D + H_BP_D;
    localparam int V_TOTAL = V_ACTIVE_D + V_FP_D + V_SYNC_D + V_BP_D;

    typedef struct packed {
        logic [1:0] r;
        logic [1:0] g;
        logic [1:0] b;
    } rgb222_t;

    // Control word carried alongside the renderer: {hsync_n, vsync_n, active}.
    localparam logic [2:0] CTRL_BLANK = 3'b110;

    function automatic logic [7:0] pack_tinyvga(input logic hs_n, input logic vs_n,
                                                input rgb222_t rgb);
        return {hs_n, rgb.b[0], rgb.g[0], rgb.r[0], vs_n, rgb.b[1], rgb.g[1], rgb.r[1]};
    endfunction

endpackage

// File: rtl/vga_out_stage_delay.sv
// Fixed-depth shift register that keeps sync/active aligned with renderer latency.
// DEPTH=0 degenerates to a wire.
module vga_delay_line #(
    parameter int               WIDTH     = 3,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_bypass
            assign dout = din;
            wire unused_dl = &{1'b0, clk, rst_n};
        end else begin : g_shift
            logic [WIDTH-1:0] stage [DEPTH];

            // NOTE: every stage is reset, otherwise stale syncs would leak out after reset.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++) stage[i] <= RESET_VAL;
                end else begin
                    stage[0] <= din;
                    for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
                end
            end

            assign dout = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_out_stage.sv
// VGA timing generator and TinyVGA PMOD output register for the demo core.
// Optional PWM audio output is enabled by defining VGA_OUT_AUDIO_PWM_EN.
module vga_out_stage
    import vga_out_pkg::*;
#(
    parameter int PIX_LAT  = 1,
    parameter int H_ACTIVE = H_ACTIVE_D,
    parameter int H_FP     = H_FP_D,
    parameter int H_SYNC   = H_SYNC_D,
    parameter int H_BP     = H_BP_D,
    parameter int V_ACTIVE = V_ACTIVE_D,
    parameter int V_FP     = V_FP_D,
    parameter int V_SYNC   = V_SYNC_D,
    parameter int V_BP     = V_BP_D
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] rgb_in,
    input  logic [7:0] audio_in,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       active,
    output logic       new_frame,
    output logic [7:0] frame,
    output logic [7:0] uo_out,
    output logic       audio_pwm
);

    localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic       hsync_n;
    logic       vsync_n;
    logic [2:0] ctrl_dly;
    rgb222_t    rgb_vis;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x     <= '0;
            y     <= '0;
            frame <= '0;
        end else if (x == H_LAST) begin
            x <= '0;
            if (y == V_LAST) begin
                y     <= '0;
                frame <= frame + 8'd1;
            end else begin
                y <= y + 10'd1;
            end
        end else begin
            x <= x + 10'd1;
        end
    end

    assign active    = (x < H_ACT) && (y < V_ACT);
    assign new_frame = (x == '0) && (y == '0);
    assign hsync_n   = !((x >= HS_START) && (x <= HS_END));
    assign vsync_n   = !((y >= VS_START) && (y <= VS_END));

    vga_delay_line #(
        .WIDTH    (3),
        .DEPTH    (PIX_LAT),
        .RESET_VAL(CTRL_BLANK)
    ) u_ctrl_dly (
        .clk  (clk),
        .rst_n(rst_n),
        .din  ({hsync_n, vsync_n, active}),
        .dout (ctrl_dly)
    );

    // Colour is forced black outside the visible area, whatever the renderer returns.
    assign rgb_vis = ctrl_dly[0] ? rgb222_t'(rgb_in) : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) uo_out <= 8'h00;
        else        uo_out <= pack_tinyvga(ctrl_dly[2], ctrl_dly[1], rgb_vis);
    end

`ifdef VGA_OUT_AUDIO_PWM_EN
    logic [7:0] sample;
    logic [7:0] pwm_cnt;

    // Sample is refreshed once per line; the comparator output is registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sample    <= '0;
            pwm_cnt   <= '0;
            audio_pwm <= 1'b0;
        end else begin
            if (x == '0) sample <= audio_in;
            pwm_cnt   <= pwm_cnt + 8'd1;
            audio_pwm <= (pwm_cnt < sample);
        end
    end
`else
    assign audio_pwm = 1'b0;
    wire unused_audio = &{1'b0, audio_in};
`endif

endmodule

// File: tb/tb_vga_out_stage.sv
// Self-checking bench: a default 640x480 instance and a shrunken-timing instance
// run in lock step against a cycle-count based reference model.
module tb_vga_out_stage;

    // Big instance: full VGA timing, PIX_LAT=1.
    localparam int B_LAT = 1;
    localparam int B_HA = 640, B_HFP = 16, B_HS = 96, B_HBP = 48;
    localparam int B_VA = 480, B_VFP = 10, B_VS = 2,  B_VBP = 33;
    // Small instance: 25x10 frame so 256 frames fit in a short run, PIX_LAT=2.
    localparam int S_LAT = 2;
    localparam int S_HA = 16, S_HFP = 2, S_HS = 4, S_HBP = 3;
    localparam int S_VA = 5,  S_VFP = 1, S_VS = 2, S_VBP = 2;

    logic       clk;
    logic       rst_n;
    logic [5:0] rgb_b, rgb_s;
    logic [7:0] audio_in;

    logic [9:0] x_b, y_b, x_s, y_s;
    logic       act_b, act_s, nf_b, nf_s, pwm_b, pwm_s;
    logic [7:0] frame_b, frame_s, uo_b, uo_s;

    int checks = 0;
    int errors = 0;
    int t      = 0;   // cycles since the last reset edge
    int rgb_mode = 0;
    logic [5:0] rgb_prev_b, rgb_prev_s;
    logic [7:0] cnt_m, samp_m;
    logic       pwm_m;

    vga_out_stage #(
        .PIX_LAT(B_LAT), .H_ACTIVE(B_HA), .H_FP(B_HFP), .H_SYNC(B_HS), .H_BP(B_HBP),
        .V_ACTIVE(B_VA), .V_FP(B_VFP), .V_SYNC(B_VS), .V_BP(B_VBP)
    ) dut_big (
        .clk(clk), .rst_n(rst_n), .rgb_in(rgb_b), .audio_in(audio_in),
        .x(x_b), .y(y_b), .active(act_b), .new_frame(nf_b), .frame(frame_b),
        .uo_out(uo_b), .audio_pwm(pwm_b)
    );

    vga_out_stage #(
        .PIX_LAT(S_LAT), .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
        .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP)
    ) dut_small (
        .clk(clk), .rst_n(rst_n), .rgb_in(rgb_s), .audio_in(audio_in),
        .x(x_s), .y(y_s), .active(act_s), .new_frame(nf_s), .frame(frame_s),
        .uo_out(uo_s), .audio_pwm(pwm_s)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (t=%0d)", tag, obs, exp, t);
        end
    endtask

    // Coordinate n cycles after reset release, from plain division.
    function automatic int coord_x(int n, int ht);
        return n % ht;
    endfunction

    function automatic int coord_y(int n, int ht, int vt);
        return (n / ht) % vt;
    endfunction

    // Expected output byte: reset value, then blank-with-syncs-idle while the
    // delay line drains, then the byte for the coordinate lat+1 cycles back.
    function automatic logic [7:0] exp_uo(int tt, int lat, int ha, int hfp, int hs, int hbp,
                                          int va, int vfp, int vs, int vbp, logic [5:0] rgb);
        int n, xx, yy, ht, vt;
        logic h_n, v_n, a;
        logic [5:0] c;
        if (tt == 0) return 8'h00;
        if (tt <= lat) return 8'h88;
        n  = tt - lat - 1;
        ht = ha + hfp + hs + hbp;
        vt = va + vfp + vs + vbp;
        xx = coord_x(n, ht);
        yy = coord_y(n, ht, vt);
        h_n = !(xx >= ha + hfp && xx < ha + hfp + hs);
        v_n = !(yy >= va + vfp && yy < va + vfp + vs);
        a   = (xx < ha) && (yy < va);
        c   = a ? rgb : 6'd0;
        return {h_n, c[0], c[2], c[4], v_n, c[1], c[3], c[5]};
    endfunction

    task automatic check_dut(input string nm, input int lat, input int ha, input int hfp,
                             input int hs, input int hbp, input int va, input int vfp,
                             input int vs, input int vbp, input logic [5:0] rgb_prev,
                             input logic [9:0] ox, input logic [9:0] oy, input logic oact,
                             input logic onf, input logic [7:0] ofr, input logic [7:0] ouo);
        int ht, vt, ex, ey;
        ht = ha + hfp + hs + hbp;
        vt = va + vfp + vs + vbp;
        ex = coord_x(t, ht);
        ey = coord_y(t, ht, vt);
        check({nm, ".x"}, 16'(ox), 16'(ex));
        check({nm, ".y"}, 16'(oy), 16'(ey));
        check({nm, ".active"}, 16'(oact), 16'((ex < ha) && (ey < va)));
        check({nm, ".new_frame"}, 16'(onf), 16'((ex == 0) && (ey == 0)));
        check({nm, ".frame"}, 16'(ofr), 16'((t / (ht * vt)) % 256));
        check({nm, ".uo_out"}, 16'(ouo),
              16'(exp_uo(t, lat, ha, hfp, hs, hbp, va, vfp, vs, vbp, rgb_prev)));
    endtask

    task automatic cycle();
        logic r;
        r = rst_n;
        rgb_prev_b = rgb_b;
        rgb_prev_s = rgb_s;
        // PWM audio reference: compare-then-count, sample refreshed at line start.
        if (!r) begin
            cnt_m = 8'd0; samp_m = 8'd0; pwm_m = 1'b0;
        end else begin
            pwm_m = (cnt_m < samp_m);
            if (coord_x(t, B_HA + B_HFP + B_HS + B_HBP) == 0) samp_m = audio_in;
            cnt_m = cnt_m + 8'd1;
        end
        @(posedge clk);
        @(negedge clk);
        if (!r) t = 0;
        else    t++;
        rgb_b = (rgb_mode == 0) ? 6'h3F : 6'($urandom);
        rgb_s = (rgb_mode == 0) ? 6'h3F : 6'($urandom);
        check_dut("big", B_LAT, B_HA, B_HFP, B_HS, B_HBP, B_VA, B_VFP, B_VS, B_VBP,
                  rgb_prev_b, x_b, y_b, act_b, nf_b, frame_b, uo_b);
        check_dut("small", S_LAT, S_HA, S_HFP, S_HS, S_HBP, S_VA, S_VFP, S_VS, S_VBP,
                  rgb_prev_s, x_s, y_s, act_s, nf_s, frame_s, uo_s);
`ifdef VGA_OUT_AUDIO_PWM_EN
        check("big.audio_pwm", 16'(pwm_b), 16'(pwm_m));
`else
        check("big.audio_pwm", 16'(pwm_b), 16'd0);
`endif
        check("small.audio_pwm_idle", 16'(pwm_s & !r), 16'd0);
    endtask

    initial begin
        rst_n    = 1'b0;
        rgb_b    = 6'h3F;
        rgb_s    = 6'h3F;
        audio_in = 8'd64;
        cnt_m    = 8'd0;
        samp_m   = 8'd0;
        pwm_m    = 1'b0;
        @(negedge clk);

        repeat (3) cycle();
        check("reset.uo_out", 16'(uo_b), 16'h00);

        rst_n = 1'b1;
        while (t < 64300) begin
            if (t == 800)   rgb_mode = 1;
            if (t == 20000) audio_in = 8'd0;
            if (t == 30000) audio_in = 8'd255;
            if (t == 40000) audio_in = 8'($urandom);
            cycle();
            if (t == 2)     check("first_white", 16'(uo_b), 16'hFF);
            if (t == 800)   check("line_wrap.y", 16'(y_b), 16'd1);
            if (t == 63999) check("frame_255", 16'(frame_s), 16'd255);
            if (t == 64000) check("frame_wrap", 16'(frame_s), 16'd0);
        end

        // Mid-frame reset: big instance sits at x=300, small one mid-frame.
        check("pre_reset.x", 16'(x_b), 16'd300);
        rst_n = 1'b0;
        cycle();
        check("mid_reset.x", 16'(x_b), 16'd0);
        check("mid_reset.frame", 16'(frame_s), 16'd0);
        check("mid_reset.uo_out", 16'(uo_s), 16'h00);
        rst_n = 1'b1;
        repeat (300) cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
